// File: rtl/act_pkg.sv
// Shared constants for the activation-engine arbiter: default widths and latencies,
// engine mode encoding and arbiter state encoding.
package act_pkg;

  localparam int ACT_DW        = 16;
  localparam int ACT_TAG_W     = 4;
  localparam int ACT_LAT_E     = 13;
  localparam int ACT_LAT_S     = 15;
  localparam int ACT_MAX_BURST = 4;

  localparam logic MODE_EXP = 1'b0;
  localparam logic MODE_SP  = 1'b1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_OWN_S = 2'd1;
  localparam logic [1:0] ST_OWN_E = 2'd2;

endpackage

// File: rtl/act_tag_pipe.sv
// Fixed-depth shift register of issue records; tap N holds the record issued N cycles ago.
module act_tag_pipe
  import act_pkg::*;
#(
  parameter int DEPTH = ACT_LAT_S,
  parameter int W     = ACT_TAG_W + 2,
  parameter int TAP_A = ACT_LAT_E,
  parameter int TAP_B = ACT_LAT_S
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] tap_a_o,
  output logic [W-1:0] tap_b_o
);

  logic [DEPTH-1:0][W-1:0] stage_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q <= '0;
    end else begin
      stage_q <= {stage_q[DEPTH-2:0], d_i};
    end
  end

  assign tap_a_o = stage_q[TAP_A-1];
  assign tap_b_o = stage_q[TAP_B-1];

endmodule

// File: rtl/act_engine_arb.sv
// Arbitrates softplus/exp requesters onto one shared activation engine and
// routes the engine's fixed-latency results back to the right requester with its tag.
module act_engine_arb
  import act_pkg::*;
#(
  parameter int DW        = ACT_DW,
  parameter int TAG_W     = ACT_TAG_W,
  parameter int LAT_E     = ACT_LAT_E,
  parameter int LAT_S     = ACT_LAT_S,
  parameter int MAX_BURST = ACT_MAX_BURST
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             s_valid_i,
  output logic             s_ready_o,
  input  logic [DW-1:0]    s_x_i,
  input  logic [TAG_W-1:0] s_tag_i,
  input  logic             e_valid_i,
  output logic             e_ready_o,
  input  logic [DW-1:0]    e_x_i,
  input  logic [TAG_W-1:0] e_tag_i,
  output logic             eng_valid_o,
  output logic             eng_mode_o,
  output logic [DW-1:0]    eng_x_o,
  input  logic [DW-1:0]    eng_y_s_i,
  input  logic             eng_valid_s_i,
  input  logic [DW-1:0]    eng_y_e_i,
  input  logic             eng_valid_e_i,
  output logic             s_valid_o,
  output logic [DW-1:0]    s_y_o,
  output logic [TAG_W-1:0] s_tag_o,
  output logic             e_valid_o,
  output logic [DW-1:0]    e_y_o,
  output logic [TAG_W-1:0] e_tag_o,
  output logic             busy_o,
  output logic [4:0]       inflight_o,
  output logic             err_o
);
  // state  | meaning
  // IDLE   | nothing granted last cycle
  // OWN_S  | softplus was granted last cycle; burst_q = its consecutive grants
  // OWN_E  | exp was granted last cycle; burst_q = its consecutive grants

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int GW = $clog2(LAT_S + 1);
  localparam int EW = TAG_W + 2;

  logic [1:0]       state_q, state_d;
  logic [BW-1:0]    burst_q, burst_d, burst_inc;
  logic             keep_owner, grant_s, grant_e;
  logic             eng_valid_q, eng_mode_q;
  logic [DW-1:0]    eng_x_q;
  logic [TAG_W-1:0] eng_tag_q;
  logic [4:0]       inflight_q, inflight_d;
  logic [GW-1:0]    guard_q;
  logic             err_q, err_now;
  logic [EW-1:0]    ent_e, ent_s;
  logic             e_hit, s_hit;

  assign keep_owner = burst_q < BW'(MAX_BURST);
  assign burst_inc  = keep_owner ? burst_q + BW'(1) : burst_q;

  always_comb begin
    grant_s = 1'b0;
    grant_e = 1'b0;
    if (!rst && en_i) begin
      if (s_valid_i && !e_valid_i) begin
        grant_s = 1'b1;
      end else if (e_valid_i && !s_valid_i) begin
        grant_e = 1'b1;
      end else if (s_valid_i && e_valid_i) begin
        case (state_q)
          ST_OWN_S: begin grant_s = keep_owner;  grant_e = !keep_owner; end
          ST_OWN_E: begin grant_e = keep_owner;  grant_s = !keep_owner; end
          default:  grant_s = 1'b1;
        endcase
      end
    end
  end

  always_comb begin
    state_d = ST_IDLE;
    burst_d = '0;
    if (grant_s) begin
      state_d = ST_OWN_S;
      burst_d = (state_q == ST_OWN_S) ? burst_inc : BW'(1);
    end else if (grant_e) begin
      state_d = ST_OWN_E;
      burst_d = (state_q == ST_OWN_E) ? burst_inc : BW'(1);
    end
  end

  act_tag_pipe #(
    .DEPTH(LAT_S),
    .W    (EW),
    .TAP_A(LAT_E),
    .TAP_B(LAT_S)
  ) u_tag_pipe (
    .clk    (clk),
    .rst    (rst),
    .d_i    ({eng_valid_q, eng_mode_q, eng_tag_q}),
    .tap_a_o(ent_e),
    .tap_b_o(ent_s)
  );

  assign e_hit = ent_e[EW-1] && (ent_e[TAG_W] == MODE_EXP);
  assign s_hit = ent_s[EW-1] && (ent_s[TAG_W] == MODE_SP);

  assign e_valid_o = !rst && eng_valid_e_i && e_hit;
  assign e_y_o     = e_valid_o ? eng_y_e_i : '0;
  assign e_tag_o   = e_valid_o ? ent_e[TAG_W-1:0] : '0;
  assign s_valid_o = !rst && eng_valid_s_i && s_hit;
  assign s_y_o     = s_valid_o ? eng_y_s_i : '0;
  assign s_tag_o   = s_valid_o ? ent_s[TAG_W-1:0] : '0;

  // Stray results are tolerated while guard_q runs: they belong to ops discarded by reset.
  assign err_now = (eng_valid_e_i && !e_hit && (guard_q == '0))
                 || (eng_valid_s_i && !s_hit && (guard_q == '0))
                 || (e_hit && !eng_valid_e_i)
                 || (s_hit && !eng_valid_s_i);

  assign inflight_d = inflight_q + {4'd0, eng_valid_q} - {4'd0, s_valid_o} - {4'd0, e_valid_o};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      burst_q     <= '0;
      eng_valid_q <= 1'b0;
      eng_mode_q  <= MODE_EXP;
      eng_x_q     <= '0;
      eng_tag_q   <= '0;
      inflight_q  <= '0;
      guard_q     <= GW'(LAT_S);
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      burst_q     <= burst_d;
      eng_valid_q <= grant_s || grant_e;
      eng_mode_q  <= grant_s ? MODE_SP : MODE_EXP;
      eng_x_q     <= grant_s ? s_x_i : (grant_e ? e_x_i : '0);
      eng_tag_q   <= grant_s ? s_tag_i : (grant_e ? e_tag_i : '0);
      inflight_q  <= inflight_d;
      if (guard_q != '0) begin
        guard_q <= guard_q - GW'(1);
      end
      err_q <= err_q || err_now;
    end
  end

  assign s_ready_o   = grant_s;
  assign e_ready_o   = grant_e;
  assign eng_valid_o = eng_valid_q;
  assign eng_mode_o  = eng_mode_q;
  assign eng_x_o     = eng_x_q;
  assign inflight_o  = inflight_q;
  assign busy_o      = (inflight_q != '0) || eng_valid_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_act_engine_arb.sv
// Bench for act_engine_arb: a reactive engine model plus a rule-level reference model
// of grants, issues, responses, in-flight count and the sticky error.
module tb_act_engine_arb;
  import act_pkg::*;

  localparam int DW    = ACT_DW;
  localparam int TAG_W = ACT_TAG_W;
  localparam int LAT_E = ACT_LAT_E;
  localparam int LAT_S = ACT_LAT_S;
  localparam int MB    = ACT_MAX_BURST;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en_i = 1'b0, s_valid_i = 1'b0, e_valid_i = 1'b0;
  logic [DW-1:0] s_x_i = '0, e_x_i = '0, eng_y_s_i = '0, eng_y_e_i = '0;
  logic [TAG_W-1:0] s_tag_i = '0, e_tag_i = '0;
  logic eng_valid_s_i = 1'b0, eng_valid_e_i = 1'b0;
  logic s_ready_o, e_ready_o, eng_valid_o, eng_mode_o, s_valid_o, e_valid_o, busy_o, err_o;
  logic [DW-1:0] eng_x_o, s_y_o, e_y_o;
  logic [TAG_W-1:0] s_tag_o, e_tag_o;
  logic [4:0] inflight_o;

  always #5 clk = ~clk;

  act_engine_arb #(.DW(DW), .TAG_W(TAG_W), .LAT_E(LAT_E), .LAT_S(LAT_S), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst), .en_i(en_i),
    .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .s_x_i(s_x_i), .s_tag_i(s_tag_i),
    .e_valid_i(e_valid_i), .e_ready_o(e_ready_o), .e_x_i(e_x_i), .e_tag_i(e_tag_i),
    .eng_valid_o(eng_valid_o), .eng_mode_o(eng_mode_o), .eng_x_o(eng_x_o),
    .eng_y_s_i(eng_y_s_i), .eng_valid_s_i(eng_valid_s_i),
    .eng_y_e_i(eng_y_e_i), .eng_valid_e_i(eng_valid_e_i),
    .s_valid_o(s_valid_o), .s_y_o(s_y_o), .s_tag_o(s_tag_o),
    .e_valid_o(e_valid_o), .e_y_o(e_y_o), .e_tag_o(e_tag_o),
    .busy_o(busy_o), .inflight_o(inflight_o), .err_o(err_o)
  );

  int cyc = 0, n_chk = 0, n_fail = 0;
  logic [DW-1:0] eng_e_sched[int], eng_s_sched[int];
  logic [DW+TAG_W-1:0] exp_e[int], exp_s[int];
  logic [DW:0] exp_iss[int];
  int m_inflight = 0, owner = 0, streak = 0;
  bit m_err = 1'b0, drop_s = 1'b0;

  function automatic logic [DW-1:0] fe(input logic [DW-1:0] x);
    return x ^ 16'h5A5A;
  endfunction
  function automatic logic [DW-1:0] fs(input logic [DW-1:0] x);
    return x + 16'h0101;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, want);
    end
  endtask

  task automatic step(input bit r, input bit en, input bit sv, input bit ev,
                      input logic [DW-1:0] sx, input logic [TAG_W-1:0] st,
                      input logic [DW-1:0] ex, input logic [TAG_W-1:0] et);
    int g;
    bit iss, dl_e, dl_s, dropped;
    @(negedge clk);
    iss = exp_iss.exists(cyc);
    chk("eng_valid", eng_valid_o, iss);
    if (iss) begin
      chk("eng_mode", eng_mode_o, exp_iss[cyc][DW]);
      chk("eng_x", eng_x_o, exp_iss[cyc][DW-1:0]);
    end
    chk("inflight", inflight_o, m_inflight);
    chk("busy", busy_o, (m_inflight != 0) || iss);
    chk("err", err_o, m_err);
    if (eng_valid_o) begin
      if (eng_mode_o) eng_s_sched[cyc+LAT_S] = fs(eng_x_o);
      else            eng_e_sched[cyc+LAT_E] = fe(eng_x_o);
    end
    rst = r; en_i = en; s_valid_i = sv; e_valid_i = ev;
    s_x_i = sx; s_tag_i = st; e_x_i = ex; e_tag_i = et;
    eng_valid_e_i = 1'b0; eng_y_e_i = '0;
    if (eng_e_sched.exists(cyc)) begin eng_valid_e_i = 1'b1; eng_y_e_i = eng_e_sched[cyc]; end
    dropped = 1'b0; eng_valid_s_i = 1'b0; eng_y_s_i = '0;
    if (eng_s_sched.exists(cyc)) begin
      if (drop_s) begin dropped = 1'b1; drop_s = 1'b0; end
      else begin eng_valid_s_i = 1'b1; eng_y_s_i = eng_s_sched[cyc]; end
    end
    g = 0;
    if (!r && en) begin
      if (sv && !ev) g = 1;
      else if (ev && !sv) g = 2;
      else if (sv && ev) g = (owner == 0) ? 1 : ((streak < MB) ? owner : 3 - owner);
    end
    #1;
    chk("s_ready", s_ready_o, g == 1);
    chk("e_ready", e_ready_o, g == 2);
    dl_e = !r && exp_e.exists(cyc);
    dl_s = !r && exp_s.exists(cyc) && !dropped;
    chk("e_valid", e_valid_o, dl_e);
    if (dl_e) begin
      chk("e_tag", e_tag_o, exp_e[cyc][TAG_W-1:0]);
      chk("e_y", e_y_o, exp_e[cyc][DW+TAG_W-1:TAG_W]);
    end
    chk("s_valid", s_valid_o, dl_s);
    if (dl_s) begin
      chk("s_tag", s_tag_o, exp_s[cyc][TAG_W-1:0]);
      chk("s_y", s_y_o, exp_s[cyc][DW+TAG_W-1:TAG_W]);
    end
    if (r) begin
      exp_e.delete(); exp_s.delete(); exp_iss.delete();
      m_inflight = 0; m_err = 1'b0; owner = 0; streak = 0;
    end else begin
      m_inflight = m_inflight + int'(iss) - int'(dl_e) - int'(dl_s);
      m_err = m_err | dropped;
      if (g == 0) begin owner = 0; streak = 0; end
      else if (g == owner) streak = (streak < MB) ? streak + 1 : MB;
      else begin owner = g; streak = 1; end
      if (g == 1) begin exp_iss[cyc+1] = {1'b1, sx}; exp_s[cyc+1+LAT_S] = {fs(sx), st}; end
      if (g == 2) begin exp_iss[cyc+1] = {1'b0, ex}; exp_e[cyc+1+LAT_E] = {fe(ex), et}; end
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b1, 1'b0, 1'b0, '0, '0, '0, '0);
  endtask

  task automatic rstep(input bit r, input bit en, input bit sv, input bit ev);
    step(r, en, sv, ev, 16'($urandom), TAG_W'($urandom), 16'($urandom), TAG_W'($urandom));
  endtask

  typedef struct { bit s_v; bit e_v; bit en; bit xs; bit xe; } vec_t;
  vec_t vt[23];

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, found;
    vt[0]  = '{1,1,1,1,0}; vt[1]  = '{1,1,1,1,0}; vt[2]  = '{1,1,1,1,0}; vt[3]  = '{1,1,1,1,0};
    vt[4]  = '{1,1,1,0,1}; vt[5]  = '{1,1,1,0,1}; vt[6]  = '{1,1,1,0,1}; vt[7]  = '{1,1,1,0,1};
    vt[8]  = '{1,1,1,1,0}; vt[9]  = '{0,1,1,0,1}; vt[10] = '{0,0,1,0,0}; vt[11] = '{1,0,0,0,0};
    vt[12] = '{1,1,0,0,0}; vt[13] = '{1,1,1,1,0}; vt[14] = '{0,1,1,0,1}; vt[15] = '{1,1,1,0,1};
    vt[16] = '{1,0,1,1,0}; vt[17] = '{1,0,1,1,0}; vt[18] = '{1,0,1,1,0}; vt[19] = '{1,0,1,1,0};
    vt[20] = '{1,0,1,1,0}; vt[21] = '{1,0,1,1,0}; vt[22] = '{1,1,1,0,1};

    rst = 1'b1; en_i = 1'b1; s_valid_i = 1'b1; e_valid_i = 1'b1;
    @(negedge clk); @(negedge clk); #1;
    chk("rst_s_ready", s_ready_o, 0);
    chk("rst_e_ready", e_ready_o, 0);
    chk("rst_eng_valid", eng_valid_o, 0);
    chk("rst_inflight", inflight_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_resp", {s_valid_o, e_valid_o}, 0);

    for (int i = 0; i < 23; i++) begin
      rstep(1'b0, vt[i].en, vt[i].s_v, vt[i].e_v);
      chk("tbl_s_ready", s_ready_o, vt[i].xs);
      chk("tbl_e_ready", e_ready_o, vt[i].xe);
    end
    idle(20);

    t0 = cyc;
    step(1'b0, 1'b1, 1'b0, 1'b1, '0, '0, 16'h3C00, 4'd3);
    idle(1);
    chk("single_issue", {eng_valid_o, eng_mode_o}, 2'b10);
    chk("single_x", eng_x_o, 16'h3C00);
    found = -1;
    for (int i = 0; i < 20; i++) begin
      idle(1);
      if (e_valid_o && found < 0) begin
        found = cyc - 1;
        chk("single_tag", e_tag_o, 3);
      end
    end
    chk("single_lat", found, t0 + 1 + LAT_E);
    chk("single_inflight", inflight_o, 0);

    t0 = cyc;
    step(1'b0, 1'b1, 1'b1, 1'b0, 16'h1234, 4'd5, '0, '0);
    idle(1);
    step(1'b0, 1'b1, 1'b0, 1'b1, '0, '0, 16'h4321, 4'd9);
    idle(14);
    chk("both_ret_cyc", cyc - 1, t0 + 16);
    chk("both_ret", {s_valid_o, e_valid_o}, 2'b11);
    chk("both_tags", {s_tag_o, e_tag_o}, {4'd5, 4'd9});
    idle(5);

    repeat (5) rstep(1'b0, 1'b1, 1'b1, 1'b1);
    repeat (20) begin
      rstep(1'b0, 1'b0, 1'b1, 1'b1);
      chk("en_low_ready", {s_ready_o, e_ready_o}, 2'b00);
    end
    chk("en_low_busy", busy_o, 0);

    repeat (3) rstep(1'b0, 1'b1, 1'b1, 1'b0);
    rstep(1'b1, 1'b1, 1'b1, 1'b1);
    idle(1);
    chk("rst_mid_eng", eng_valid_o, 0);
    chk("rst_mid_inflight", inflight_o, 0);
    idle(20);
    chk("rst_mid_err", err_o, 0);

    repeat (300) rstep(($urandom % 64) == 0, ($urandom % 8) != 0, 1'($urandom), 1'($urandom));
    idle(20);

    drop_s = 1'b1;
    step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0AAA, 4'd1, '0, '0);
    step(1'b0, 1'b1, 1'b0, 1'b1, '0, '0, 16'h0BBB, 4'd2);
    idle(20);
    chk("drop_err", err_o, 1);
    idle(3);
    chk("drop_err_sticky", err_o, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/act_engine_arb.md
ACT_ENGINE_ARB -- requirements
Module: act_engine_arb

Interface
REQ-001 SHALL have parameters: DW=16, FP16 word width; TAG_W=4, requester tag width; LAT_E=13, engine issue-to-exp-result cycles; LAT_S=15, engine issue-to-softplus-result cycles; MAX_BURST=4, maximum consecutive grants to one requester under contention.
REQ-002 SHALL have ports:
  clk  in  1  sole clock, rising edge;
  rst  in  1  reset, synchronous, active-high;
  en_i  in  1  grant enable;
  s_valid_i/s_ready_o  in/out  1  softplus request handshake;
  s_x_i  in  DW  softplus operand;  s_tag_i  in  TAG_W  softplus tag;
  e_valid_i/e_ready_o  in/out  1  exp request handshake;
  e_x_i  in  DW  exp operand;  e_tag_i  in  TAG_W  exp tag;
  eng_valid_o  out  1  engine issue strobe;  eng_mode_o  out  1  1=softplus, 0=exp;  eng_x_o  out  DW  engine operand;
  eng_y_s_i/eng_valid_s_i  in  DW/1  engine softplus result;
  eng_y_e_i/eng_valid_e_i  in  DW/1  engine exp result;
  s_valid_o, s_y_o, s_tag_o  out  1/DW/TAG_W  softplus response;
  e_valid_o, e_y_o, e_tag_o  out  1/DW/TAG_W  exp response;
  busy_o  out  1  any op in flight or issuing;
  inflight_o  out  5  ops issued whose result has not returned;
  err_o  out  1  sticky protocol error.

Function
REQ-003 SHALL accept a request on a cycle where valid_i and ready_o are both high; at most one of s_ready_o/e_ready_o SHALL be high per cycle.
REQ-004 SHALL drive ready_o combinationally from en_i, the current state and both valid_i; ready_o SHALL be low whenever en_i is low.
REQ-005 SHALL use FSM states IDLE, OWN_S, OWN_E plus a burst counter (0..MAX_BURST).
REQ-006 Grant rules: only one valid -> grant it; both valid in IDLE -> grant S; both valid in OWN_x -> keep x while burst count < MAX_BURST, else grant other.
REQ-007 Transitions: grant to a requester other than the owner -> OWN_that, burst=1; grant to owner -> burst+1 (saturating); no grant -> IDLE, burst=0.
REQ-008 SHALL register the accepted request so eng_valid_o, eng_mode_o, eng_x_o appear exactly 1 cycle after handshake; eng_valid_o SHALL be low otherwise; up to one issue per cycle, no bubbles.
REQ-009 SHALL carry {valid, mode, tag} for every issue in a LAT_S-deep tag pipeline starting at the eng_valid_o cycle.
REQ-010 SHALL present an exp result on e_valid_o/e_y_o/e_tag_o in the same cycle eng_valid_e_i is high (combinational pass of data, tag from pipeline stage LAT_E).
REQ-011 SHALL present a softplus result on s_valid_o/s_y_o/s_tag_o in the same cycle eng_valid_s_i is high, tag from stage LAT_S.
REQ-012 Responses have no back-pressure; consumers SHALL accept every response.
REQ-013 SHALL set err_o when eng_valid_e_i is high without a valid mode-0 entry at stage LAT_E, or eng_valid_s_i high without a valid mode-1 entry at stage LAT_S, or a tagged entry reaches its stage without the matching engine valid; the unmatched response SHALL be suppressed.
REQ-014 inflight_o SHALL increment on eng_valid_o, decrement on each s_valid_o/e_valid_o, both in one cycle -> unchanged; width holds LAT_S+1.
REQ-015 busy_o SHALL be high when inflight_o != 0 or eng_valid_o is high.
REQ-016 Simultaneous exp and softplus returns (ops of different modes issued LAT_S-LAT_E cycles apart) SHALL both be delivered in that cycle.
REQ-017 en_i falling SHALL stop new grants only; in-flight ops SHALL complete and be delivered.

Reset
REQ-018 On rst high at a clock edge: state IDLE, burst 0, tag pipeline cleared, all outputs 0 incl. err_o and inflight_o, ready_o low during rst.
REQ-019 Reset mid-operation SHALL discard all in-flight tags; engine results arriving after reset SHALL be ignored without raising err_o for LAT_S cycles following reset release.

Structure
REQ-020 DW, TAG_W, mode encodings, state encoding and default LAT_E/LAT_S SHALL live in a shared package act_pkg.
REQ-021 SHALL contain one sub-module act_tag_pipe (parameterised depth/width shift register with tap outputs) for the tag pipeline.

Verification
REQ-022 Single exp request x=0x3C00 tag 3 -> eng_valid_o, mode 0 one cycle later; model returns at +13 -> e_valid_o, e_tag_o=3, inflight_o back to 0.
REQ-023 Both requesters valid continuously -> grant pattern S,S,S,S,E,E,E,E,S... ; no cycle with both ready high.
REQ-024 S issue at cycle t, E issue at t+2 -> s_valid_o and e_valid_o both high at cycle t+1+15, correct tags.
REQ-025 Model drops one eng_valid_s_i -> err_o sets and stays 1; unrelated results still delivered.
REQ-026 en_i low with 5 ops in flight -> ready_o low, all 5 responses delivered, busy_o falls after last.
REQ-027 rst pulsed with 3 ops in flight -> outputs 0, late engine results produce no response and err_o stays 0.
